// File: rtl/spi_rb_pkg.sv
// spi_rb_pkg: shared FSM state type and constants for the SPI to register-bank bridge.
package spi_rb_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, FETCH, DATA, SKIP} state_e;
    localparam int SPI_RB_CMD_WR_BIT = 7;
    localparam int SPI_RB_SYNC_STAGES = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser with registered rise/fall pulses (pulse appears 3 clk after the raw edge).
module spi_sync_edge
    import spi_rb_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [SPI_RB_SYNC_STAGES-1:0] sync_q;
    logic dly_q, rise_q, fall_q;
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= {SPI_RB_SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SPI_RB_SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SPI_RB_SYNC_STAGES-1];
            rise_q <= sync_q[SPI_RB_SYNC_STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[SPI_RB_SYNC_STAGES-1] & dly_q;
        end
    end
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/spi_rb_bridge.sv
// spi_rb_bridge: SPI mode-0 slave turning command/address/data frames into register-bank accesses.
// Define SPI_RB_AUTOINC_EN for burst frames with address auto-increment; otherwise extra bytes are skipped.
module spi_rb_bridge
    import spi_rb_pkg::*;
#(
    parameter int ADR_BITS = 8
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                spi_sclk,
    input  logic                spi_csn,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic [ADR_BITS-1:0] address,
    output logic [7:0]          data_write_in,
    input  logic [7:0]          data_read_out,
    output logic                reg_en,
    output logic                write_en,
    output logic                frame_abort
);
`ifdef SPI_RB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;
    logic [SPI_RB_SYNC_STAGES-1:0] mosi_sync_q;
    state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] sh_q, sh_d;
    logic [7:0] miso_sr_q, miso_sr_d, wdata_q, wdata_d, byte_in;
    logic rw_q, rw_d, fetch_wait_q, fetch_wait_d, miso_q, miso_d;
    logic reg_en_q, reg_en_d, write_en_q, write_en_d, abort_q, abort_d;
    logic [ADR_BITS-1:0] addr_q, addr_d, address_q, address_d, addr_inc;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .resetb(resetb), .d_i(spi_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_csn (.clk(clk), .resetb(resetb), .d_i(spi_csn), .rise_o(csn_rise), .fall_o(csn_fall));

    assign mosi_s   = mosi_sync_q[SPI_RB_SYNC_STAGES-1];
    assign byte_in  = {sh_q, mosi_s};
    assign addr_inc = ADR_BITS'(addr_q + 1'b1);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        miso_sr_d    = miso_sr_q;
        miso_d       = miso_q;
        fetch_wait_d = 1'b0;
        address_d    = address_q;
        wdata_d      = wdata_q;
        reg_en_d     = 1'b0;
        write_en_d   = 1'b0;
        abort_d      = 1'b0;
        if (sclk_fall && state_q != IDLE) begin
            miso_d    = miso_sr_q[7];
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end
        // Bytes dropped in SKIP are not partial frames, so they never flag an abort.
        if (csn_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            abort_d   = (bit_cnt_q != 3'd0) && (state_q != SKIP);
            miso_sr_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (csn_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    miso_sr_d = '0;
                    miso_d    = 1'b0;
                end
                FETCH: begin
                    fetch_wait_d = ~fetch_wait_q;
                    if (fetch_wait_q) begin
                        miso_sr_d = data_read_out;
                        state_d   = DATA;
                    end
                end
                default: if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    sh_d      = byte_in[6:0];
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            CMD: begin
                                rw_d    = byte_in[SPI_RB_CMD_WR_BIT];
                                state_d = ADDR;
                            end
                            ADDR: begin
                                addr_d    = byte_in[ADR_BITS-1:0];
                                address_d = byte_in[ADR_BITS-1:0];
                                reg_en_d  = ~rw_q;
                                state_d   = rw_q ? DATA : FETCH;
                            end
                            DATA: begin
                                if (rw_q) begin
                                    address_d  = addr_q;
                                    wdata_d    = byte_in;
                                    write_en_d = 1'b1;
                                    reg_en_d   = 1'b1;
                                    addr_d     = addr_inc;
                                    state_d    = AUTOINC ? DATA : SKIP;
                                end else if (AUTOINC) begin
                                    address_d = addr_inc;
                                    reg_en_d  = 1'b1;
                                    addr_d    = addr_inc;
                                    state_d   = FETCH;
                                end else begin
                                    state_d = SKIP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mosi_sync_q  <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            miso_sr_q    <= '0;
            miso_q       <= 1'b0;
            fetch_wait_q <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            reg_en_q     <= 1'b0;
            write_en_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            mosi_sync_q  <= {mosi_sync_q[SPI_RB_SYNC_STAGES-2:0], spi_mosi};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_q         <= sh_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            miso_sr_q    <= miso_sr_d;
            miso_q       <= miso_d;
            fetch_wait_q <= fetch_wait_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            reg_en_q     <= reg_en_d;
            write_en_q   <= write_en_d;
            abort_q      <= abort_d;
        end
    end

    assign spi_miso      = miso_q & ~spi_csn;
    assign address       = address_q;
    assign data_write_in = wdata_q;
    assign reg_en        = reg_en_q;
    assign write_en      = write_en_q;
    assign frame_abort   = abort_q;
endmodule

// File: doc/spi_rb_bridge.md
# spi_rb_bridge

SPI slave front end that converts SPI frames from the external host into single-cycle accesses on the register-bank bus: `address`, `data_write_in`, `write_en`, `reg_en` and the registered `data_read_out`. It sits directly upstream of the FPGA register bank and is the only master on that bus. SPI runs in mode 0, MSB first, and is oversampled in the `clk` domain. The block supports single and burst (auto-increment) read/write frames.

## Interface
- `ADR_BITS`, default 8: register-bank address width, range 1..8. The address byte is truncated to its low `ADR_BITS` bits.
- `clk`, in, 1: system clock.
- `resetb`, in, 1: asynchronous active-low reset. Deassertion is synchronous to `clk` externally.
- `spi_sclk`, in, 1: SPI clock, asynchronous to `clk`.
- `spi_csn`, in, 1: chip select, active low, asynchronous.
- `spi_mosi`, in, 1: host-to-device data.
- `spi_miso`, out, 1: device-to-host data. Driven to 0 while `spi_csn` is high; never tristated.
- `address`, out, `ADR_BITS`: register-bank address.
- `data_write_in`, out, 8: register-bank write data.
- `data_read_out`, in, 8: register-bank read data, valid one `clk` after `address`.
- `reg_en`, out, 1: one-cycle access strobe, issued for reads and writes.
- `write_en`, out, 1: one-cycle write strobe, coincident with `reg_en`.
- `frame_abort`, out, 1: one-cycle pulse when `spi_csn` rises mid-byte.

## Operation
- Synchronisation: `spi_sclk`, `spi_csn` and `spi_mosi` each pass a 2-FF synchroniser. Edge detect happens on the synchronised `sclk`/`csn`.
  - `sclk` rise samples MOSI.
  - `sclk` fall shifts MISO.
- Frame format, byte 0 (command): bit7 = 1 for write, 0 for read. Bits 6:0 are ignored.
- Frame format, byte 1: address.
- Frame format, bytes 2..n: data.
- FSM states:
  - IDLE: wait for `csn` fall, then go to CMD.
  - CMD: 8 bits, latch the R/W flag, go to ADDR.
  - ADDR: 8 bits, latch the address. On the 8th rise, a read goes to FETCH; a write goes to DATA.
  - FETCH: drive `address`, pulse `reg_en`; wait one cycle; capture `data_read_out` into the MISO shift register; go to DATA.
  - DATA: 8 bits. At the 8th rise:
    - Write: drive `address`/`data_write_in`, pulse `write_en`+`reg_en`.
    - Then increment the address, modulo 2^`ADR_BITS`, so 0xFF wraps to 0x00.
    - Read: go to FETCH. Write: stay in DATA.
- MISO during CMD/ADDR is 0. During a read DATA byte it shifts the captured byte MSB first. During a write DATA byte it is 0.
- `csn` rise in any state returns the FSM to IDLE and clears the bit counter.
  - If the bit counter is non-zero, pulse `frame_abort`; the partial byte issues no access.
  - An access already issued completes.
- `csn` fall while not IDLE (glitch shorter than the synchroniser) is ignored.
- A write frame that ends after the address byte issues no access.
- A read frame ending after the address byte still performs one fetch. This is harmless.

## Timing
- Reset values: `spi_miso`=0, `address`=0, `data_write_in`=0, `reg_en`=0, `write_en`=0, `frame_abort`=0, FSM=IDLE.
- Synchroniser plus edge-detect latency: 3 `clk`.
- Write latency: `write_en` asserts 4 `clk` after the raw 8th `sclk` rise of the data byte. It stays high exactly 1 cycle.
- Read path: `reg_en` at sync-rise+1. `data_read_out` is captured at +2. It is loaded into MISO before the next synchronised `sclk` fall.
- Requirement: f_clk ≥ 16·f_sclk, i.e. ≥8 `clk` per `sclk` half-period. The host holds `csn` ≥2 `clk` high between frames.
- `write_en` and `reg_en` never assert while FSM=IDLE, CMD or ADDR.

## Configuration
- `SPI_RB_AUTOINC_EN` defined: burst frames as above, with unlimited data bytes and address auto-increment.
- `SPI_RB_AUTOINC_EN` undefined: only the first data byte accesses the bank. After it the FSM enters a SKIP state until `csn` rises. In SKIP:
  - MISO is 0.
  - No `reg_en`/`write_en`.
  - No `frame_abort` is raised for bytes in SKIP.

## Structure
- Shared package `spi_rb_pkg`:
  - FSM state enum (IDLE, CMD, ADDR, FETCH, DATA, SKIP).
  - `SPI_RB_CMD_WR_BIT` = 7.
  - `SPI_RB_SYNC_STAGES` = 2.
- One sub-module: `spi_sync_edge`, a 2-FF synchroniser with rise/fall pulse outputs. It is instantiated for `sclk` and `csn`; MOSI uses the synchroniser only.

## Test plan
- Write frame 0x80, 0x40, 0x1F → one `write_en` pulse with `address`=0x40, `data_write_in`=0x1F. No other strobes.
- Read frame 0x00, 0x01, 0x00 against the bank model holding 0x85 at address 1 → MISO byte 2 = 0x85. `reg_en` pulses once; `write_en` stays 0.
- Burst write (autoinc) 0x80, 0xFE, 0xAA, 0xBB, 0xCC → writes to 0xFE=0xAA, 0xFF=0xBB, 0x00=0xCC (wrap).
- Burst read without `SPI_RB_AUTOINC_EN`, 0x00, 0x04, plus 3 bytes → one fetch of 0x04. Bytes 3–4 return 0x00.
- `csn` raised after 5 bits of a write data byte → `frame_abort` pulse, no `write_en`. The next frame 0x80, 0x02, 0x55 is executed correctly.
- `resetb` asserted mid-burst → all outputs 0 immediately. After release, a fresh frame works.
